// File: rtl/led_pwm_mux.sv
// rtl/led_pwm_mux.sv - multiplexed RGB LED PWM driver with shadow/active duty buffers
// Sinks are time-shared per phase; shadow duties are copied to the active set only at frame end.
module led_pwm_mux #(
  parameter int NUM_LEDS    = 11,
  parameter int NUM_SINKS   = 3,
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 0,
  parameter logic [2*NUM_SINKS*NUM_LEDS-1:0] CHAN_MAP = {NUM_LEDS{(2*NUM_SINKS)'(8'he4)}}
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           wr_en,
  input  logic [(NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1)-1:0] wr_led,
  input  logic [1:0]                                     wr_chan,
  input  logic [PWM_BITS-1:0]                            wr_data,
  input  logic                                           commit,
  output logic                                           commit_pending,
  output logic                                           frame_start,
  output logic [NUM_LEDS-1:0]                            ledc,
  output logic [NUM_SINKS-1:0]                           ledrgb
);

  localparam int LW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int KW         = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
  localparam int SLOTS      = 1 << PWM_BITS;
  localparam int SLOT_TOTAL = SLOTS + DEAD_CYCLES;
  localparam int SW         = $clog2(SLOT_TOTAL);

  logic [SW-1:0]       slot_q, slot_d;
  logic [KW-1:0]       sink_q, sink_d;
  logic                pending_q, pending_d;
  logic                frame_start_q, frame_start_d;
  logic [NUM_LEDS-1:0] ledc_q, ledc_d;
  logic [NUM_SINKS-1:0] ledrgb_q, ledrgb_d;

  logic [PWM_BITS-1:0] shadow_q [NUM_LEDS][NUM_SINKS];
  logic [PWM_BITS-1:0] shadow_d [NUM_LEDS][NUM_SINKS];
  logic [PWM_BITS-1:0] active_q [NUM_LEDS][NUM_SINKS];
  logic [PWM_BITS-1:0] active_d [NUM_LEDS][NUM_SINKS];
  logic [PWM_BITS-1:0] duty_sel [NUM_LEDS];

  logic slot_last, sink_last, frame_end, active_slot;

  assign slot_last   = (int'(slot_q) == SLOT_TOTAL - 1);
  assign sink_last   = (int'(sink_q) == NUM_SINKS - 1);
  assign frame_end   = slot_last && sink_last;
  assign active_slot = (int'(slot_q) < SLOTS);

  always_comb begin
    slot_d = slot_q;
    sink_d = sink_q;
    if (slot_last) begin
      slot_d = '0;
      sink_d = sink_last ? '0 : sink_q + 1'b1;
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  // Out-of-range LED/channel indices simply match no storage cell.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q | commit;
    if (frame_end && (pending_q || commit)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    for (int l = 0; l < NUM_LEDS; l++) begin
      for (int c = 0; c < NUM_SINKS; c++) begin
        if (wr_en && (wr_led == LW'(l)) && (wr_chan == 2'(c))) begin
          shadow_d[l][c] = wr_data;
        end
      end
    end
  end

  // A map entry naming a channel beyond NUM_SINKS selects duty 0.
  always_comb begin
    for (int l = 0; l < NUM_LEDS; l++) begin
      duty_sel[l] = '0;
      for (int s = 0; s < NUM_SINKS; s++) begin
        for (int c = 0; c < NUM_SINKS; c++) begin
          if ((int'(sink_q) == s) && (int'(CHAN_MAP[(l*NUM_SINKS+s)*2 +: 2]) == c)) begin
            duty_sel[l] = active_q[l][c];
          end
        end
      end
    end
  end

  always_comb begin
    frame_start_d = (slot_q == '0) && (sink_q == '0);
    for (int s = 0; s < NUM_SINKS; s++) begin
      ledrgb_d[s] = active_slot && (int'(sink_q) == s);
    end
    for (int l = 0; l < NUM_LEDS; l++) begin
      ledc_d[l] = active_slot && (slot_q[PWM_BITS-1:0] < duty_sel[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      sink_q        <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      ledc_q        <= '0;
      ledrgb_q      <= '0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
    end else begin
      slot_q        <= slot_d;
      sink_q        <= sink_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      ledc_q        <= ledc_d;
      ledrgb_q      <= ledrgb_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign commit_pending = pending_q;
  assign frame_start    = frame_start_q;
  assign ledc           = ledc_q;
  assign ledrgb         = ledrgb_q;

endmodule

// File: tb/tb_led_pwm_mux.sv
// tb/tb_led_pwm_mux.sv - directed scoreboard bench for led_pwm_mux
// LED1 uses a reversed channel map; frames are 3 x (16 active + 2 dead) = 54 cycles.
module tb_led_pwm_mux;
  localparam int NL    = 3;
  localparam int NS    = 3;
  localparam int PB    = 4;
  localparam int DC    = 2;
  localparam int PHASE = 16 + DC;
  localparam int FRAME = NS * PHASE;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_led;
  logic [1:0]    wr_chan;
  logic [PB-1:0] wr_data;
  logic          commit;
  logic          commit_pending;
  logic          frame_start;
  logic [NL-1:0] ledc;
  logic [NS-1:0] ledrgb;

  always #5 clk = ~clk;

  led_pwm_mux #(
    .NUM_LEDS(NL), .NUM_SINKS(NS), .PWM_BITS(PB), .DEAD_CYCLES(DC),
    .CHAN_MAP({6'h24, 6'h06, 6'h24})
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_led(wr_led), .wr_chan(wr_chan),
    .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .frame_start(frame_start), .ledc(ledc), .ledrgb(ledrgb)
  );

  typedef struct {int led; int sink; int cnt;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_act [NL][NS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] l, input logic [1:0] c, input logic [PB-1:0] d);
    wr_led = l; wr_chan = c; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // LED1 wiring is reversed: physical sink s shows logical channel 2-s.
  task automatic push_expected();
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < NS; s++)
        sb.push_back('{l, s, exp_act[l][(l == 1) ? NS - 1 - s : s]});
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 4 * FRAME) begin
      step();
      n++;
    end
    check("frame_start_wait", frame_start, 1);
  endtask

  task automatic measure_frame(input string name);
    int hi [NL][NS];
    int bad_rgb = 0, bad_dead = 0, bad_fs = 0, first = -1, last = -1;
    logic [NS-1:0] er;
    exp_t e;
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < NS; s++) hi[l][s] = 0;
    for (int i = 0; i < FRAME; i++) begin
      er = '0;
      if ((i % PHASE) < 16) er[i / PHASE] = 1'b1;
      if (ledrgb !== er) bad_rgb++;
      if (frame_start !== (i == 0)) bad_fs++;
      if (er == '0 && ledc !== '0) bad_dead++;
      for (int l = 0; l < NL; l++)
        for (int s = 0; s < NS; s++)
          if (ledrgb[s] === 1'b1 && ledc[l] === 1'b1) hi[l][s]++;
      if (ledc[0] === 1'b1 && ledrgb === 3'b010) begin
        if (first < 0) first = i;
        last = i;
      end
      step();
    end
    check({name, " rgb_pattern_errs"}, bad_rgb, 0);
    check({name, " dead_ledc_errs"}, bad_dead, 0);
    check({name, " frame_start_errs"}, bad_fs, 0);
    check({name, " frame_period"}, frame_start, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.led < 0)
        check($sformatf("%s led0_sink1_%s", name, (e.sink == 0) ? "first" : "last"),
              (e.sink == 0) ? first : last, e.cnt);
      else
        check($sformatf("%s led%0d_sink%0d_hi", name, e.led, e.sink), hi[e.led][e.sink], e.cnt);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_led = '0; wr_chan = '0; wr_data = '0; commit = 1'b0;
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < NS; s++) exp_act[l][s] = 0;

    repeat (2) step();
    check("reset ledc", ledc, 0);
    check("reset ledrgb", ledrgb, 0);
    check("reset frame_start", frame_start, 0);
    check("reset pending", commit_pending, 0);
    rst = 1'b0;
    step();
    check("first frame_start", frame_start, 1);
    check("first ledrgb", ledrgb, 1);
    push_expected();
    measure_frame("idle");

    write(0, 1, 5);
    do_commit();
    check("pending set", commit_pending, 1);
    exp_act[0][1] = 5;
    wait_fs();
    check("pending cleared", commit_pending, 0);
    push_expected();
    sb.push_back('{-1, 0, PHASE});
    sb.push_back('{-1, 1, PHASE + 4});
    measure_frame("duty5");

    write(0, 0, 15);
    write(0, 1, 0);
    do_commit();
    exp_act[0][0] = 15; exp_act[0][1] = 0;
    wait_fs();
    push_expected();
    measure_frame("duty15_0");

    write(1, 0, 3);
    write(1, 2, 9);
    do_commit();
    exp_act[1][0] = 3; exp_act[1][2] = 9;
    wait_fs();
    push_expected();
    measure_frame("chanmap");

    write(2, 0, 7);
    wait_fs();
    for (int f = 0; f < 3; f++) begin
      push_expected();
      measure_frame($sformatf("nocommit%0d", f));
    end
    repeat (20) step();
    do_commit();
    exp_act[2][0] = 7;
    wait_fs();
    check("led2 at frame_start", ledc[2], 1);
    push_expected();
    measure_frame("midcommit");

    // Align the 12 write (plus a redundant commit) with the frame-end cycle.
    write(0, 0, 4);
    do_commit();
    check("edge pending set", commit_pending, 1);
    repeat (50) step();
    wr_led = 2'd0; wr_chan = 2'd0; wr_data = 4'd12; wr_en = 1'b1; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    step();
    check("edge frame_start", frame_start, 1);
    check("edge pending cleared", commit_pending, 0);
    exp_act[0][0] = 4;
    push_expected();
    measure_frame("edge_write");
    do_commit();
    exp_act[0][0] = 12;
    wait_fs();
    push_expected();
    measure_frame("recommit");

    write(0, 1, 3);
    do_commit();
    check("pre_rst pending", commit_pending, 1);
    check("pre_rst ledc0", ledc[0], 1);
    rst = 1'b1;
    step();
    check("mid_rst ledc", ledc, 0);
    check("mid_rst ledrgb", ledrgb, 0);
    check("mid_rst frame_start", frame_start, 0);
    check("mid_rst pending", commit_pending, 0);
    rst = 1'b0;
    step();
    check("post_rst frame_start", frame_start, 1);
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < NS; s++) exp_act[l][s] = 0;
    push_expected();
    measure_frame("after_rst");

    write(2'd3, 0, 9);
    write(0, 2'd3, 9);
    do_commit();
    wait_fs();
    push_expected();
    measure_frame("out_of_range");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_pwm_mux.md
# led_pwm_mux

Parametrised multiplexed RGB LED PWM driver for the badge LED matrix: NUM_LEDS common-source LED lines (`ledc`) time-shared across NUM_SINKS colour sinks (`ledrgb`). Each LED/channel has a PWM_BITS duty value. Values are written into a shadow buffer and committed atomically at a frame boundary, so updates never tear. A per-LED channel map absorbs board-level colour-order differences, and a programmable dead time blanks all sinks between phases to suppress ghosting. It replaces the fixed 11-LED, 8-bit, 3-sink driver in the top level.

## Interface
- NUM_LEDS, 11, number of LED source lines
- NUM_SINKS, 3, number of colour sinks / logical channels (1..4)
- PWM_BITS, 8, duty resolution; slots per phase = 2^PWM_BITS
- DEAD_CYCLES, 0, blanking cycles after each phase (0..255)
- CHAN_MAP, identity, 2*NUM_SINKS*NUM_LEDS bits; field `[(l*NUM_SINKS+s)*2 +: 2]` = logical channel shown on LED l while physical sink s is active

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  shadow write strobe
- wr_led  in  clog2(NUM_LEDS)  LED index
- wr_chan  in  2  logical channel index
- wr_data  in  PWM_BITS  duty value
- commit  in  1  request a shadow→active copy at the next frame end
- commit_pending  out  1  commit requested, not yet applied
- frame_start  out  1  one-cycle pulse coincident with the first output cycle of a frame
- ledc  out  NUM_LEDS  LED source drives, registered
- ledrgb  out  NUM_SINKS  sink enables, one-hot or zero, registered

## Operation
- Counters: `sink` runs 0..NUM_SINKS-1; `slot` runs 0..2^PWM_BITS+DEAD_CYCLES-1.
- `slot` wraps to 0 and advances `sink`; `sink` wraps to 0, which ends the frame.
- Frame length = NUM_SINKS*(2^PWM_BITS+DEAD_CYCLES) cycles.
- Active slot (`slot` < 2^PWM_BITS):
  - `ledrgb` = 1<<`sink`.
  - `ledc[l]` = (`slot` < active[l][CHAN_MAP(l,`sink`)]), unsigned PWM_BITS compare.
- Dead slot (`slot` ≥ 2^PWM_BITS): `ledrgb`=0, `ledc`=0.
- Duty 0 gives a fully off channel. Duty 2^PWM_BITS-1 is on for 2^PWM_BITS-1 of 2^PWM_BITS slots.
- Writes:
  - wr_en writes shadow[wr_led][wr_chan] = wr_data.
  - Writes with wr_led ≥ NUM_LEDS or wr_chan ≥ NUM_SINKS are ignored.
  - The active buffer is never written directly.
- Commit:
  - commit sets commit_pending.
  - On the last cycle of a frame with commit_pending=1, active ← shadow in full and commit_pending clears on the next cycle.
  - Repeated commits while pending have no extra effect.
- Simultaneous events:
  - wr_en on the frame-end copy cycle: active receives the pre-write shadow value; the write stays in shadow for the next commit.
  - commit on the frame-end cycle is applied at that boundary.
  - commit on the frame-end cycle with pending already set: one copy, pending clears.

## Timing
- Outputs are registered, with a 1-cycle latency from the counter state to `ledc`/`ledrgb`/`frame_start`.
- Reset values: `ledc`=0, `ledrgb`=0, frame_start=0, commit_pending=0, shadow and active all 0, `sink`=0, `slot`=0.
- Reset mid-frame aborts the frame immediately; a pending commit is dropped.
- First cycle after rst deasserts: counters at (0,0). Next cycle: `ledrgb`=1, frame_start=1.
- A commit becomes visible on the first output cycle of the following frame, at latest one frame plus 1 cycle after the commit pulse.
- Every `ledrgb` change passes through ≥1 all-zero cycle when DEAD_CYCLES≥1. With DEAD_CYCLES=0, sinks switch directly.

## Test plan
- Reset, then run with PWM_BITS=4, DEAD_CYCLES=2, NUM_SINKS=3 → `ledc`=0 throughout. `ledrgb` cycles 001 for 16 cycles, 000 for 2, 010 for 16, 000 for 2, 100 for 16, 000 for 2. frame_start fires every 54 cycles.
- Write LED0 ch1=5, commit → pending high until frame end. In the next frame, `ledc[0]` is high for exactly 5 cycles, in slots 0-4 while `ledrgb`=010, and low elsewhere. Duty 15 gives 15 high cycles. Duty 0 gives none.
- CHAN_MAP for LED1 = {R,G,B} reversed. Write ch0=3, ch2=9, commit → `ledc[1]` is high 9 cycles under sink 0 and 3 cycles under sink 2.
- Write LED2 ch0=7 without commit → no `ledc[2]` activity for 3 frames. Then commit mid-frame → the change appears exactly at the next frame_start.
- On the frame-end cycle with pending set, write LED0 ch0=12 (shadow previously 4) → the next frame shows 4. Commit again → the following frame shows 12.
- Assert rst mid-phase → all outputs are 0 the next cycle, active is cleared, and pending=0. Out-of-range write (wr_led=NUM_LEDS) → no `ledc` change after commit.
